// File: rtl/apb_watchdog.sv
`timescale 1ns/1ps
// APB watchdog: prescaled down-counter that raises a warning interrupt on the
// first expiry and a sticky reset request on a second expiry without a kick.
module apb_watchdog #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [31:0] KICK_KEY       = 32'h5A5A_A5A5,
  parameter logic [31:0] LOAD_RESET     = 32'hFFFF_FFFF
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      dbg_halt_i,
  output logic                      irq_o,
  output logic                      rst_req_o
);

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_VALUE    = 3'd2;
  localparam logic [2:0] OFF_KICK     = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, WARN, BITE} state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d, rst_en_q, rst_en_d, lock_q, lock_d;
  logic [31:0] load_q, load_d, value_q, value_d;
  logic [15:0] prescale_q, prescale_d, pcnt_q, pcnt_d;
  logic        to1_q, to1_d, badkey_q, badkey_d, bite_q, bite_d;

  logic [2:0]  off;
  logic        access, wr_ok, active, tick, key_ok;
  logic        ctrl_wr, load_wr, kick_wr, status_wr, prescale_wr;
  logic        unused_paddr;

  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  assign off         = PADDR[4:2];
  assign access      = PSEL & PENABLE;
  assign PREADY      = 1'b1;
  assign wr_ok       = access & PWRITE & ~PSLVERR;
  assign ctrl_wr     = wr_ok & (off == OFF_CTRL);
  assign load_wr     = wr_ok & (off == OFF_LOAD);
  assign kick_wr     = wr_ok & (off == OFF_KICK);
  assign status_wr   = wr_ok & (off == OFF_STATUS);
  assign prescale_wr = wr_ok & (off == OFF_PRESCALE);
  assign key_ok      = (PWDATA == KICK_KEY);

  assign active = (state_q == RUN) || (state_q == WARN);
  assign tick   = active && !dbg_halt_i && (pcnt_q == prescale_q);

  assign irq_o     = to1_q | badkey_q;
  assign rst_req_o = bite_q;

  always_comb begin
    PSLVERR = 1'b0;
    if (access) begin
      case (off)
        OFF_CTRL, OFF_LOAD, OFF_PRESCALE: PSLVERR = PWRITE & lock_q;
        OFF_VALUE:                        PSLVERR = PWRITE;
        OFF_KICK, OFF_STATUS:             PSLVERR = 1'b0;
        default:                          PSLVERR = 1'b1;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (off)
        OFF_CTRL:     PRDATA = {29'd0, lock_q, rst_en_q, en_q};
        OFF_LOAD:     PRDATA = load_q;
        OFF_VALUE:    PRDATA = value_q;
        OFF_STATUS:   PRDATA = {29'd0, bite_q, badkey_q, to1_q};
        OFF_PRESCALE: PRDATA = {16'd0, prescale_q};
        default:      PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    rst_en_d   = rst_en_q;
    lock_d     = lock_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    to1_d      = to1_q;
    badkey_d   = badkey_q;
    bite_d     = bite_q;

    if (active && !dbg_halt_i) begin
      pcnt_d = tick ? '0 : pcnt_q + 16'd1;
    end

    if (ctrl_wr) begin
      rst_en_d = PWDATA[1];
      lock_d   = lock_q | PWDATA[2];
      if (state_q != BITE) en_d = PWDATA[0];
    end
    if (load_wr)     load_d     = PWDATA;
    if (prescale_wr) prescale_d = PWDATA[15:0];
    // W1C is applied before the FSM so a same-cycle expiry set takes priority
    if (status_wr && state_q != BITE) begin
      to1_d    = to1_q & ~PWDATA[0];
      badkey_d = badkey_q & ~PWDATA[1];
    end

    case (state_q)
      IDLE: begin
        if (ctrl_wr && PWDATA[0]) begin
          state_d = RUN;
          value_d = load_q;
          pcnt_d  = '0;
        end
      end
      RUN, WARN: begin
        if (ctrl_wr && !PWDATA[0]) begin
          state_d = IDLE;
        end else if (kick_wr && key_ok) begin
          state_d = RUN;
          value_d = load_q;
          pcnt_d  = '0;
        end else if (kick_wr) begin
          badkey_d = 1'b1;
          if (rst_en_q) begin
            state_d = BITE;
            bite_d  = 1'b1;
          end
        end else if (tick) begin
          if (value_q != '0) begin
            value_d = value_q - 32'd1;
          end else if (state_q == RUN) begin
            to1_d   = 1'b1;
            value_d = load_q;
            state_d = WARN;
          end else if (rst_en_q) begin
            bite_d  = 1'b1;
            state_d = BITE;
          end else begin
            value_d = load_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      rst_en_q   <= 1'b0;
      lock_q     <= 1'b0;
      load_q     <= LOAD_RESET;
      value_q    <= LOAD_RESET;
      prescale_q <= '0;
      pcnt_q     <= '0;
      to1_q      <= 1'b0;
      badkey_q   <= 1'b0;
      bite_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      rst_en_q   <= rst_en_d;
      lock_q     <= lock_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      to1_q      <= to1_d;
      badkey_q   <= badkey_d;
      bite_q     <= bite_d;
    end
  end

endmodule

// File: tb/tb_apb_watchdog.sv
`timescale 1ns/1ps
// Scoreboard bench for apb_watchdog: stimulus pushes expected responses,
// a negedge monitor pops them on every APB access or pin probe.
module tb_apb_watchdog;

  localparam logic [31:0] KEY = 32'h5A5A_A5A5;
  localparam logic [11:0] A_CTRL = 12'h000, A_LOAD = 12'h004, A_VALUE = 12'h008,
                          A_KICK = 12'h00C, A_STAT = 12'h010, A_PRE = 12'h014,
                          A_U18 = 12'h018, A_U1C = 12'h01C;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        dbg_halt_i = 1'b0;
  logic        irq_o, rst_req_o;
  logic        probe = 1'b0;

  typedef struct {
    bit          is_probe;
    bit          chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
    bit          chk_pins;
    logic        exp_irq;
    logic        exp_rst;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];
  int    n_chk = 0;
  int    n_pass = 0;
  exp_t  e;
  string nm;

  apb_watchdog #(
    .APB_ADDR_WIDTH(12),
    .KICK_KEY      (32'h5A5A_A5A5),
    .LOAD_RESET    (32'hFFFF_FFFF)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .dbg_halt_i(dbg_halt_i),
    .irq_o     (irq_o),
    .rst_req_o (rst_req_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  always @(negedge HCLK) begin
    if ((PSEL && PENABLE) || probe) begin
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL scoreboard_empty: unexpected event at %0t", $time);
      end else begin
        e  = sbq.pop_front();
        nm = nameq.pop_front();
        if (e.is_probe != probe) begin
          n_chk++;
          $display("FAIL %s: event kind probe=%0d expected probe=%0d", nm, probe, e.is_probe);
        end else begin
          if (!e.is_probe) begin
            check({nm, ".pslverr"}, {31'd0, PSLVERR}, {31'd0, e.exp_err});
            check({nm, ".pready"}, {31'd0, PREADY}, 32'd1);
            if (e.chk_data) check({nm, ".prdata"}, PRDATA, e.exp_data);
          end
          if (e.chk_pins) begin
            check({nm, ".irq"}, {31'd0, irq_o}, {31'd0, e.exp_irq});
            check({nm, ".rst_req"}, {31'd0, rst_req_o}, {31'd0, e.exp_rst});
          end
        end
      end
    end
  end

  task automatic push(input bit ip, input bit cd, input logic [31:0] d, input logic err,
                      input bit cp, input logic irq, input logic rst, input string name);
    exp_t x;
    x.is_probe = ip; x.chk_data = cd; x.exp_data = d; x.exp_err = err;
    x.chk_pins = cp; x.exp_irq = irq; x.exp_rst = rst;
    sbq.push_back(x);
    nameq.push_back(name);
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr_chk(input logic [11:0] a, input logic [31:0] d, input logic err,
                            input bit cp, input logic irq, input logic rst, input string name);
    push(1'b0, 1'b0, '0, err, cp, irq, rst, name);
    bus(1'b1, a, d);
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic err,
                        input string name);
    apb_wr_chk(a, d, err, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic apb_rd(input logic [11:0] a, input logic [31:0] expv, input logic err,
                        input string name);
    push(1'b0, 1'b1, expv, err, 1'b0, 1'b0, 1'b0, name);
    bus(1'b0, a, '0);
  endtask

  task automatic probe_pins(input logic irq, input logic rst, input string name);
    push(1'b1, 1'b0, '0, 1'b0, 1'b1, irq, rst, name);
    probe = 1'b1;
    @(negedge HCLK); #1;
    probe = 1'b0;
  endtask

  // Reset asserted mid-cycle; the probe lands before any further clock edge.
  task automatic do_reset(input string name);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    probe_pins(1'b0, 1'b0, name);
    wait_cyc(2);
    HRESETn = 1'b1;
    wait_cyc(1);
  endtask

  initial begin
    wait_cyc(3);
    HRESETn = 1'b1;
    wait_cyc(1);

    // Reset values
    probe_pins(1'b0, 1'b0, "rst_pins");
    apb_rd(A_CTRL,  32'h0,         1'b0, "rst_ctrl");
    apb_rd(A_LOAD,  32'hFFFF_FFFF, 1'b0, "rst_load");
    apb_rd(A_VALUE, 32'hFFFF_FFFF, 1'b0, "rst_value");
    apb_rd(A_KICK,  32'h0,         1'b0, "rst_kick");
    apb_rd(A_STAT,  32'h0,         1'b0, "rst_status");
    apb_rd(A_PRE,   32'h0,         1'b0, "rst_prescale");
    apb_wr(A_KICK, 32'h1, 1'b0, "idle_badkick");
    apb_rd(A_STAT, 32'h0, 1'b0, "idle_badkick_ignored");
    apb_wr(A_PRE, 32'hABCD_0003, 1'b0, "pre_wr");
    apb_rd(A_PRE, 32'h0000_0003, 1'b0, "pre_upper_zero");

    // Two-stage expiry: LOAD=3, PRESCALE=1, enable at E0
    apb_wr(A_LOAD, 32'd3, 1'b0, "s2_load");
    apb_wr(A_PRE, 32'd1, 1'b0, "s2_pre");
    apb_wr(A_CTRL, 32'h3, 1'b0, "s2_en");
    wait_cyc(7);
    probe_pins(1'b0, 1'b0, "s2_e7");
    wait_cyc(1);
    probe_pins(1'b1, 1'b0, "s2_to1_e8");
    apb_rd(A_VALUE, 32'd2, 1'b0, "s2_value_e10");
    wait_cyc(4);
    probe_pins(1'b1, 1'b0, "s2_e15");
    wait_cyc(1);
    probe_pins(1'b1, 1'b1, "s2_bite_e16");
    apb_rd(A_STAT, 32'h5, 1'b0, "s2_status");
    apb_rd(A_VALUE, 32'h0, 1'b0, "s2_value_frozen");
    apb_wr_chk(A_KICK, KEY, 1'b0, 1'b1, 1'b1, 1'b1, "s2_kick_in_bite");
    apb_wr(A_STAT, 32'h3, 1'b0, "s2_w1c_in_bite");
    apb_rd(A_STAT, 32'h5, 1'b0, "s2_status_sticky");
    probe_pins(1'b1, 1'b1, "s2_still_bite");
    do_reset("s2_async_reset");

    // Periodic valid kicks, then a bad key with RST_EN=1
    apb_wr(A_LOAD, 32'd10, 1'b0, "s3_load");
    apb_wr(A_PRE, 32'd1, 1'b0, "s3_pre");
    apb_wr(A_CTRL, 32'h3, 1'b0, "s3_en");
    for (int i = 0; i < 14; i++) begin
      wait_cyc(12);
      apb_wr_chk(A_KICK, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "s3_kick");
    end
    wait_cyc(12);
    apb_rd(A_STAT, 32'h0, 1'b0, "s3_no_to1");
    apb_wr_chk(A_KICK, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, "s3_badkick");
    probe_pins(1'b1, 1'b1, "s3_badkick_bite");
    apb_rd(A_STAT, 32'h6, 1'b0, "s3_status");
    do_reset("s3_reset");

    // Lock and error responses
    apb_wr(A_CTRL, 32'h5, 1'b0, "s4_en_lock");
    apb_wr(A_LOAD, 32'h0, 1'b1, "s4_load_locked");
    apb_rd(A_LOAD, 32'hFFFF_FFFF, 1'b0, "s4_load_kept");
    apb_wr(A_CTRL, 32'h0, 1'b1, "s4_ctrl_locked");
    apb_rd(A_CTRL, 32'h5, 1'b0, "s4_ctrl_kept");
    apb_rd(A_VALUE, 32'hFFFF_FFF1, 1'b0, "s4_still_running");
    apb_rd(A_U18, 32'h0, 1'b1, "s4_rd_0x18");
    apb_wr(A_VALUE, 32'h0, 1'b1, "s4_wr_value");
    apb_wr(A_U1C, 32'h0, 1'b1, "s4_wr_0x1c");
    apb_wr(A_PRE, 32'h7, 1'b1, "s4_pre_locked");
    apb_rd(A_PRE, 32'h0, 1'b0, "s4_pre_kept");
    do_reset("s4_reset");

    // RST_EN=0: warning only, W1C, set-wins against same-cycle expiry
    apb_wr(A_LOAD, 32'd2, 1'b0, "s5_load");
    apb_wr(A_CTRL, 32'h1, 1'b0, "s5_en");
    wait_cyc(2);
    probe_pins(1'b0, 1'b0, "s5_e2");
    wait_cyc(1);
    probe_pins(1'b1, 1'b0, "s5_to1_e3");
    apb_wr(A_STAT, 32'h1, 1'b0, "s5_w1c");
    probe_pins(1'b0, 1'b0, "s5_cleared");
    apb_wr(A_KICK, KEY, 1'b0, "s5_kick");
    probe_pins(1'b0, 1'b0, "s5_after_kick");
    wait_cyc(2);
    probe_pins(1'b0, 1'b0, "s5_e11");
    wait_cyc(1);
    probe_pins(1'b1, 1'b0, "s5_reset_to1");
    apb_wr_chk(A_KICK, KEY, 1'b0, 1'b1, 1'b1, 1'b0, "s5_kick2");
    apb_wr(A_STAT, 32'h1, 1'b0, "s5_w1c_vs_set");
    probe_pins(1'b1, 1'b0, "s5_set_wins");
    apb_rd(A_STAT, 32'h1, 1'b0, "s5_status");
    wait_cyc(20);
    probe_pins(1'b1, 1'b0, "s5_no_rst_req");
    do_reset("s5_reset");

    // Debug halt, kick during halt, kick beats tick, deferred LOAD
    apb_wr(A_LOAD, 32'd100, 1'b0, "s6_load");
    apb_wr(A_CTRL, 32'h1, 1'b0, "s6_en");
    wait_cyc(4);
    dbg_halt_i = 1'b1;
    apb_rd(A_VALUE, 32'd96, 1'b0, "s6_halt_value");
    wait_cyc(50);
    apb_rd(A_VALUE, 32'd96, 1'b0, "s6_halt_value_50");
    apb_wr(A_KICK, KEY, 1'b0, "s6_halt_kick");
    apb_rd(A_VALUE, 32'd100, 1'b0, "s6_halt_reload");
    dbg_halt_i = 1'b0;
    apb_rd(A_VALUE, 32'd98, 1'b0, "s6_resume");
    apb_wr(A_KICK, KEY, 1'b0, "s6_kick_tick");
    apb_rd(A_VALUE, 32'd98, 1'b0, "s6_kick_wins");
    apb_wr(A_LOAD, 32'd5, 1'b0, "s6_load5");
    apb_rd(A_VALUE, 32'd92, 1'b0, "s6_load_no_effect");
    apb_wr(A_KICK, KEY, 1'b0, "s6_kick_load5");
    apb_rd(A_VALUE, 32'd3, 1'b0, "s6_new_load");

    wait_cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_watchdog.md
Name: apb_watchdog

Overview:
- APB slave on the peripheral APB bus, fed by the AXI-to-APB bridge like the other peripherals.
- Two-stage watchdog: first expiry raises a warning interrupt (routed into the event unit's irq/event vector); second expiry without service raises a sticky reset request to the SoC reset logic.
- Software services it with a keyed kick write.
- Includes a prescaler, a lock bit and a debug freeze input.

Parameters:
- APB_ADDR_WIDTH, 12, width of PADDR; registers are decoded on PADDR[4:2].
- KICK_KEY, 32'h5A5A_A5A5, the only value accepted as a valid kick.
- LOAD_RESET, 32'hFFFF_FFFF, reset value of LOAD.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  APB write data
- PWRITE  in  1  APB write strobe
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- PSLVERR  out  1  APB error
- dbg_halt_i  in  1  freezes prescaler and counter while high
- irq_o  out  1  level interrupt; equals STATUS.TO1 | STATUS.BADKEY
- rst_req_o  out  1  sticky reset request

Behaviour:
- One clock domain (HCLK). Reset is asynchronous, active-low (HRESETn). All outputs and registers are 0 at reset, except LOAD=LOAD_RESET and VALUE=LOAD_RESET.
- APB protocol:
  - PREADY is tied to 1 (zero wait states).
  - A write takes effect in the ACCESS cycle (PSEL & PENABLE & PWRITE).
  - PRDATA is combinational from PADDR[4:2] and is 0 when the access is not a read.
  - PSLVERR=1 in the ACCESS cycle for: an unmapped offset (0x18, 0x1C); any write to VALUE; a write to CTRL, LOAD or PRESCALE while LOCK=1. Writes that raise PSLVERR have no effect.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 RST_EN, bit2 LOCK. LOCK is set-only; only reset clears it.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 VALUE: read-only current count.
  - 0x0C KICK: write-only, reads 0.
  - 0x10 STATUS: bit0 TO1, bit1 BADKEY, bit2 BITE. Write 1 to clear TO1 and BADKEY; BITE is read-only.
  - 0x14 PRESCALE: bits[15:0]; bits[31:16] read 0.
- Prescaler:
  - pcnt counts 0..PRESCALE; `tick` is asserted in the cycle pcnt==PRESCALE, and pcnt returns to 0 in that same cycle.
  - PRESCALE=0 gives a tick every cycle.
  - pcnt is held while dbg_halt_i=1 or state is IDLE.
- FSM states: IDLE, RUN, WARN, BITE.
  - IDLE: EN=0. VALUE holds; no ticks.
  - IDLE -> RUN: on a CTRL write with EN=1. VALUE<=LOAD and pcnt<=0 in that cycle.
  - RUN, on tick: if VALUE!=0, VALUE<=VALUE-1. If VALUE==0: set TO1, VALUE<=LOAD, go to WARN.
  - WARN, on tick:
    - VALUE!=0: decrement.
    - VALUE==0 and RST_EN=1: set BITE, go to BITE.
    - VALUE==0 and RST_EN=0: reload and stay in WARN.
  - BITE: rst_req_o=1 (registered; asserts the cycle after the final expiry tick). Counting stops. Only HRESETn exits BITE; kicks, EN writes and W1C writes are ignored.
  - EN written 0 in RUN or WARN -> IDLE. TO1 is not cleared.
- Kick (write to KICK):
  - PWDATA==KICK_KEY in RUN or WARN: VALUE<=LOAD, pcnt<=0, state->RUN. TO1 is not cleared; software clears it via STATUS.
  - Any other value: set BADKEY; if RST_EN=1, go to BITE next cycle.
  - A kick in IDLE is ignored, including BADKEY detection.
- Simultaneous events:
  - A valid kick and a tick in the same cycle: the kick wins and no decrement occurs.
  - A W1C clear and a TO1 set in the same cycle: the set wins.
  - A LOAD write takes effect at the next reload and does not alter VALUE.
- Arithmetic: LOAD=0 gives an expiry on every tick. Warning-to-bite time is (LOAD+1)*(PRESCALE+1) cycles.
- dbg_halt_i: freezes pcnt and VALUE only. APB accesses and kicks remain functional.
- Asynchronous reset mid-operation returns every register, the FSM and rst_req_o to their reset values immediately.

Test Plan:
- Reset, then read all offsets -> CTRL=0, LOAD=0xFFFFFFFF, VALUE=0xFFFFFFFF, STATUS=0, PRESCALE=0. irq_o=0, rst_req_o=0, PREADY=1.
- LOAD=3, PRESCALE=1, CTRL=0x3 -> VALUE decrements every 2 cycles; TO1 and irq_o set 8 cycles after the enable write; rst_req_o=1 at 16 cycles +1.
- LOAD=10, run, kick with 0x5A5AA5A5 every 15 cycles for 200 cycles -> TO1 never set. Then kick with 0x12345678 and RST_EN=1 -> BADKEY=1, rst_req_o=1 next cycle.
- Write CTRL=0x5, then write LOAD=0 -> PSLVERR=1 and LOAD unchanged. Write CTRL=0x0 -> PSLVERR=1 and still running. Reads of 0x18 and a write to 0x08 -> PSLVERR=1.
- RST_EN=0, LOAD=2, PRESCALE=0 -> TO1 set and irq_o=1. Write STATUS=0x1 -> irq_o=0 next cycle; it re-sets on the next expiry and rst_req_o stays 0.
- dbg_halt_i=1 for 50 cycles mid-count -> VALUE is constant. Kick during the halt reloads VALUE. Pull HRESETn low while in BITE -> rst_req_o=0 immediately.
